// File: rtl/traffic_phase_controller.sv
// -----------------------------------------------------------------------------
// traffic_phase_controller
//
// N-way traffic-light sequencer. Green is handed round-robin among N_WAYS
// approaches, each grant running GREEN -> YELLOW -> ALLRED with fixed tick
// counts. With SKIP_IDLE=1 an approach is only granted when its req bit is
// set at the moment the all-red clearance ends; otherwise the controller
// holds all-red and re-scans each cycle. A level-sensitive flash input
// overrides everything with a flashing yellow on every approach.
//
// Every output comes straight from a flop: light is computed from the
// next-state values and registered alongside state, so a phase of K ticks is
// visible on light for exactly K clock cycles.
//
// Ports
//   clock       in   1              rising-edge clock
//   reset       in   1              asynchronous active-high reset
//   req         in   N_WAYS         per-approach demand, sampled every cycle
//   flash       in   1              1 = flashing-yellow override
//   light       out  3*N_WAYS       per approach {red,yellow,green},
//                                   approach i = light[3i+2:3i]
//   active_way  out  WAY_W          approach currently green/yellow; in
//                                   ALLRED/FLASH the approach last served
//   phase       out  2              FSM state: 00 ALLRED, 01 GREEN,
//                                   10 YELLOW, 11 FLASH
//
// The phase output is the FSM state register itself, so checkers can bind
// to it directly.
// -----------------------------------------------------------------------------
module traffic_phase_controller #(
  parameter int N_WAYS       = 2,
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1,
  parameter int FLASH_TICKS  = 4,
  parameter int SKIP_IDLE    = 1,
  localparam int WAY_W       = (N_WAYS > 2) ? $clog2(N_WAYS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_WAYS-1:0]     req,
  input  logic                  flash,
  output logic [3*N_WAYS-1:0]   light,
  output logic [WAY_W-1:0]      active_way,
  output logic [1:0]            phase
);

  // ---------------------------------------------------------------------------
  // Timer sizing: wide enough for the longest of the four tick parameters,
  // with one spare bit so the saturating count never aliases a terminal value.
  // ---------------------------------------------------------------------------
  localparam int MAX_GY = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
  localparam int MAX_AF = (ALLRED_TICKS > FLASH_TICKS) ? ALLRED_TICKS : FLASH_TICKS;
  localparam int TMAX   = (MAX_GY > MAX_AF) ? MAX_GY : MAX_AF;
  localparam int TW     = $clog2(TMAX) + 1;

  // Terminal timer values: the last cycle of each phase.
  localparam logic [TW-1:0] GREEN_LAST  = TW'(GREEN_TICKS - 1);
  localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_TICKS - 1);
  localparam logic [TW-1:0] ALLRED_LAST = TW'(ALLRED_TICKS - 1);
  localparam logic [TW-1:0] FLASH_LAST  = TW'(FLASH_TICKS - 1);

  localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(N_WAYS - 1);

  // Lamp encodings, {red,yellow,green}.
  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

  typedef enum logic [1:0] {
    S_ALLRED = 2'b00,
    S_GREEN  = 2'b01,
    S_YELLOW = 2'b10,
    S_FLASH  = 2'b11
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers and their next-state values
  // ---------------------------------------------------------------------------
  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [WAY_W-1:0]      way_q, way_d;
  logic                  blink_q, blink_d;
  logic [3*N_WAYS-1:0]   light_q, light_d;

  logic [TW-1:0]         timer_inc;
  logic                  cand_found;
  logic [WAY_W-1:0]      cand_way;

  // (base + k) mod N_WAYS. base may hold an unused encoding when N_WAYS is
  // not a power of two, so up to two corrections can be needed.
  function automatic logic [WAY_W-1:0] way_plus(input logic [WAY_W-1:0] base,
                                                 input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_WAYS) s = s - N_WAYS;
    if (s >= N_WAYS) s = s - N_WAYS;
    return WAY_W'(s);
  endfunction

  // Saturating increment: while ALLRED waits for demand the timer would
  // otherwise wrap and reopen the clearance window.
  assign timer_inc = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + 1'b1;

  // ---------------------------------------------------------------------------
  // Next-approach selection.
  // Fixed rotation simply advances. Demand-driven mode scans active_way+1
  // upward with wrap, the current approach last. The loop runs from the
  // farthest offset down to the nearest so the nearest requester is the
  // last one written and therefore wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    cand_found = 1'b0;
    cand_way   = way_plus(way_q, 1);
    if (SKIP_IDLE == 0) begin
      cand_found = 1'b1;
    end else begin
      for (int k = N_WAYS; k >= 1; k--) begin
        if (req[way_plus(way_q, k)]) begin
          cand_found = 1'b1;
          cand_way   = way_plus(way_q, k);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state. flash is checked ahead of the case so it beats every
  // timer expiry. The timer clears on every state change.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    timer_d = timer_inc;
    way_d   = way_q;
    blink_d = blink_q;

    if (flash) begin
      if (state_q != S_FLASH) begin
        // Immediate override, no yellow or all-red clearance.
        state_d = S_FLASH;
        timer_d = '0;
        blink_d = 1'b1;
      end else if (timer_q >= FLASH_LAST) begin
        timer_d = '0;
        blink_d = ~blink_q;
      end
    end else begin
      case (state_q)
        S_ALLRED: begin
          // With no demand the state holds and the scan repeats next cycle.
          if ((timer_q >= ALLRED_LAST) && cand_found) begin
            state_d = S_GREEN;
            timer_d = '0;
            way_d   = cand_way;
          end
        end
        S_GREEN: begin
          // req is ignored here: a grant always runs its full length.
          if (timer_q >= GREEN_LAST) begin
            state_d = S_YELLOW;
            timer_d = '0;
          end
        end
        S_YELLOW: begin
          if (timer_q >= YELLOW_LAST) begin
            state_d = S_ALLRED;
            timer_d = '0;
          end
        end
        S_FLASH: begin
          // Leaving the override always passes through a full clearance;
          // the served approach is kept so rotation resumes after it.
          state_d = S_ALLRED;
          timer_d = '0;
          blink_d = 1'b0;
        end
        default: begin
          state_d = S_ALLRED;
          timer_d = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Lamp decode from the next-state values, so light changes on the same
  // edge as state. Non-selected approaches stay red in GREEN/YELLOW, which
  // guarantees at most one non-red approach outside FLASH.
  // ---------------------------------------------------------------------------
  always_comb begin
    light_d = {N_WAYS{L_RED}};
    for (int i = 0; i < N_WAYS; i++) begin
      case (state_d)
        S_GREEN: begin
          if (way_d == WAY_W'(i)) light_d[3*i +: 3] = L_GRN;
        end
        S_YELLOW: begin
          if (way_d == WAY_W'(i)) light_d[3*i +: 3] = L_YEL;
        end
        S_FLASH: begin
          light_d[3*i +: 3] = blink_d ? L_YEL : L_OFF;
        end
        default: begin
          light_d[3*i +: 3] = L_RED;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset parks on the last approach so the first grant
  // after reset lands on approach 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_ALLRED;
      timer_q <= '0;
      way_q   <= LAST_WAY;
      blink_q <= 1'b0;
      light_q <= {N_WAYS{L_RED}};
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      way_q   <= way_d;
      blink_q <= blink_d;
      light_q <= light_d;
    end
  end

  assign light      = light_q;
  assign active_way = way_q;
  assign phase      = state_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// -----------------------------------------------------------------------------
// tb_traffic_phase_controller
//
// Two instances share clock and reset:
//   dut_a : N_WAYS=2, SKIP_IDLE=0 (fixed rotation)
//   dut_b : N_WAYS=4, SKIP_IDLE=1 (demand-driven)
// A behavioural model (phase + cycles remaining) pushes the expected outputs
// into a queue per instance on every clock/reset event; a compare process
// checks them on every falling edge together with safety properties.
// Directed sections pin the model with literal values, then random req/flash
// traffic runs against the model.
// -----------------------------------------------------------------------------
module tb_traffic_phase_controller;

  localparam int G  = 8;
  localparam int Y  = 2;
  localparam int AR = 1;
  localparam int FT = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]  req_a;
  logic        flash_a;
  logic [5:0]  light_a;
  logic [0:0]  way_a;
  logic [1:0]  phase_a;

  logic [3:0]  req_b;
  logic        flash_b;
  logic [11:0] light_b;
  logic [1:0]  way_b;
  logic [1:0]  phase_b;

  traffic_phase_controller #(
    .N_WAYS(2), .GREEN_TICKS(G), .YELLOW_TICKS(Y), .ALLRED_TICKS(AR),
    .FLASH_TICKS(FT), .SKIP_IDLE(0)
  ) dut_a (
    .clock(clock), .reset(reset), .req(req_a), .flash(flash_a),
    .light(light_a), .active_way(way_a), .phase(phase_a)
  );

  traffic_phase_controller #(
    .N_WAYS(4), .GREEN_TICKS(G), .YELLOW_TICKS(Y), .ALLRED_TICKS(AR),
    .FLASH_TICKS(FT), .SKIP_IDLE(1)
  ) dut_b (
    .clock(clock), .reset(reset), .req(req_b), .flash(flash_b),
    .light(light_b), .active_way(way_b), .phase(phase_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: ph 0 allred, 1 green, 2 yellow, 3 flash;
  // rem = cycles still to show in the current phase (countdown).
  // ---------------------------------------------------------------------------
  typedef struct packed {
    int   ph;
    int   way;
    int   rem;
    logic blink;
  } mstate_t;

  mstate_t ma, mb;

  function automatic mstate_t m_reset(input int n);
    mstate_t r;
    r.ph = 0; r.way = n - 1; r.rem = AR; r.blink = 1'b0;
    return r;
  endfunction

  // Next served way, or -1 when demand mode finds nobody.
  function automatic int m_pick(input int n, input bit skip, input logic [7:0] rq, input int way);
    if (!skip) return (way + 1) % n;
    for (int k = 1; k <= n; k++) begin
      if (rq[(way + k) % n]) return (way + k) % n;
    end
    return -1;
  endfunction

  function automatic mstate_t m_step(input mstate_t s, input int n, input bit skip,
                                     input logic [7:0] rq, input logic fl);
    mstate_t r;
    int nx;
    r = s;
    if (fl) begin
      if (s.ph != 3) begin
        r.ph = 3; r.blink = 1'b1; r.rem = FT;
      end else if (s.rem <= 1) begin
        r.blink = ~s.blink; r.rem = FT;
      end else begin
        r.rem = s.rem - 1;
      end
      return r;
    end
    case (s.ph)
      0: begin
        if (s.rem <= 1) begin
          nx = m_pick(n, skip, rq, s.way);
          if (nx >= 0) begin r.ph = 1; r.way = nx; r.rem = G; end
        end else r.rem = s.rem - 1;
      end
      1: if (s.rem <= 1) begin r.ph = 2; r.rem = Y; end else r.rem = s.rem - 1;
      2: if (s.rem <= 1) begin r.ph = 0; r.rem = AR; end else r.rem = s.rem - 1;
      default: begin r.ph = 0; r.rem = AR; end
    endcase
    return r;
  endfunction

  function automatic logic [23:0] m_light(input mstate_t s, input int n);
    logic [23:0] l;
    l = '0;
    for (int i = 0; i < n; i++) begin
      case (s.ph)
        1: l[3*i +: 3] = (i == s.way) ? 3'b001 : 3'b100;
        2: l[3*i +: 3] = (i == s.way) ? 3'b010 : 3'b100;
        3: l[3*i +: 3] = s.blink ? 3'b010 : 3'b000;
        default: l[3*i +: 3] = 3'b100;
      endcase
    end
    return l;
  endfunction

  // Expected {phase[28:27], way[26:24], light[23:0]}.
  function automatic logic [31:0] m_pack(input mstate_t s, input int n);
    return {3'b000, 2'(s.ph), 3'(s.way), m_light(s, n)};
  endfunction

  logic [31:0] exp_q_a[$];
  logic [31:0] exp_q_b[$];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      ma = m_reset(2);
      mb = m_reset(4);
    end else begin
      ma = m_step(ma, 2, 1'b0, 8'(req_a), flash_a);
      mb = m_step(mb, 4, 1'b1, 8'(req_b), flash_b);
    end
    exp_q_a.push_back(m_pack(ma, 2));
    exp_q_b.push_back(m_pack(mb, 4));
  end

  // ---------------------------------------------------------------------------
  // Safety properties per instance (0 = a, 1 = b)
  // ---------------------------------------------------------------------------
  int pph[2];
  int yrun[2];

  task automatic prop_check(input int id, input logic [23:0] l, input int n, input logic [1:0] ph);
    int nonred;
    string nm;
    nm = (id == 0) ? "a" : "b";
    if (reset) begin
      pph[id] = 0; yrun[id] = 0;
      return;
    end
    if (ph != 2'b11) begin
      nonred = 0;
      for (int i = 0; i < n; i++) if (l[3*i +: 3] != 3'b100) nonred++;
      check({nm, "_nonred_count"}, 32'(nonred), (ph == 2'b00) ? 32'd0 : 32'd1);
    end
    if (pph[id] == 1 && ph != 2'b01)
      check({nm, "_green_exit_to_yellow_or_flash"}, 32'(ph == 2'b00), 32'd0);
    if (ph == 2'b10) yrun[id]++;
    else begin
      if (pph[id] == 2 && ph == 2'b00) check({nm, "_yellow_len"}, 32'(yrun[id]), 32'(Y));
      yrun[id] = 0;
    end
    pph[id] = int'(ph);
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard: latest model expectation vs DUT on every falling edge
  // ---------------------------------------------------------------------------
  logic [31:0] e;

  always @(negedge clock) begin
    while (exp_q_a.size() > 1) void'(exp_q_a.pop_front());
    while (exp_q_b.size() > 1) void'(exp_q_b.pop_front());
    if (exp_q_a.size() == 0 || exp_q_b.size() == 0) begin
      total++; bad++;
      $display("FAIL model_queue: got empty expected entry at %0t", $time);
    end else begin
      e = exp_q_a.pop_front();
      check("a_light", 32'(light_a), 32'(e[5:0]));
      check("a_way",   32'(way_a),   32'(e[26:24]));
      check("a_phase", 32'(phase_a), 32'(e[28:27]));
      e = exp_q_b.pop_front();
      check("b_light", 32'(light_b), 32'(e[11:0]));
      check("b_way",   32'(way_b),   32'(e[26:24]));
      check("b_phase", 32'(phase_b), 32'(e[28:27]));
    end
    prop_check(0, 24'(light_a), 2, phase_a);
    prop_check(1, 24'(light_b), 4, phase_b);
  end

  // ---------------------------------------------------------------------------
  // Driver / directed + random stimulus
  // ---------------------------------------------------------------------------
  int  gap;
  bit  seen2;
  bit  hit;
  int  fa, fb;

  initial begin
    req_a = '0; flash_a = 1'b0; req_b = '0; flash_b = 1'b0;
    #1 reset = 1'b1;
    @(negedge clock);
    check("rst_light_a", 32'(light_a), 32'(6'b100_100));
    check("rst_way_a",   32'(way_a),   32'd1);
    check("rst_light_b", 32'(light_b), 32'h924);
    check("rst_way_b",   32'(way_b),   32'd3);
    @(negedge clock);
    reset = 1'b0;

    // Cycle-accurate rotation on a; b idles with no demand for 20 cycles.
    for (int c = 0; c <= 23; c++) begin
      if (c < 20) check("t3_b_idle_phase", 32'(phase_b), 32'd0);
      if (c == 20) begin
        check("t3_b_way3_green", 32'(light_b), 32'h324);
        check("t3_b_way3",       32'(way_b),   32'd3);
      end
      case (c)
        0:  check("t1_c0_allred",  32'(phase_a), 32'd0);
        1:  check("t1_c1_w0_grn",  32'(light_a), 32'(6'b100_001));
        8:  check("t1_c8_w0_grn",  32'(light_a), 32'(6'b100_001));
        9:  check("t1_c9_w0_yel",  32'(light_a), 32'(6'b100_010));
        11: check("t1_c11_allred", 32'(light_a), 32'(6'b100_100));
        12: check("t1_c12_w1_grn", 32'(light_a), 32'(6'b001_100));
        23: check("t1_c23_w0_grn", 32'(light_a), 32'(6'b100_001));
        default: ;
      endcase
      if (c == 19) req_b = 4'b1000;
      tick;
    end

    // Only way 2 requests: it alone is served, back-to-back.
    req_b = 4'b0100;
    gap = 0; seen2 = 0;
    for (int c = 0; c < 100; c++) begin
      if (phase_b == 2'b01) begin
        if (seen2 && gap != 0) check("t2_gap", 32'(gap), 32'(Y + AR));
        gap = 0;
        if (way_b == 2'd2) seen2 = 1;
      end else gap++;
      if (seen2) check("t2_way", 32'(way_b), 32'd2);
      tick;
    end
    check("t2_served", 32'(seen2), 32'd1);

    // Flash override in the middle of way 1's green.
    req_b = 4'b1111;
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (phase_b == 2'b01 && way_b == 2'd1) hit = 1;
      else tick;
    end
    if (!hit) begin
      total++; bad++;
      $display("FAIL t4_wait_way1: got timeout expected way1 green");
    end
    tick; tick;
    flash_b = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick;
      check("t4_flash_light", 32'(light_b), (k < 4) ? 32'h492 : 32'h000);
      check("t4_flash_phase", 32'(phase_b), 32'd3);
    end
    flash_b = 1'b0;
    tick;
    check("t4_exit_allred", 32'(light_b), 32'h924);
    check("t4_exit_way",    32'(way_b),   32'd1);
    tick;
    check("t4_w2_green",    32'(light_b), 32'h864);
    check("t4_w2_way",      32'(way_b),   32'd2);

    // Async reset between edges while a is yellow.
    hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (phase_a == 2'b10) hit = 1;
      else tick;
    end
    if (!hit) begin
      total++; bad++;
      $display("FAIL t5_wait_yellow: got timeout expected yellow");
    end
    #2 reset = 1'b1;
    #1;
    check("t5_async_light_a", 32'(light_a), 32'(6'b100_100));
    check("t5_async_phase_a", 32'(phase_a), 32'd0);
    check("t5_async_way_a",   32'(way_a),   32'd1);
    check("t5_async_light_b", 32'(light_b), 32'h924);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    tick;
    check("t5_first_green_a", 32'(light_a), 32'(6'b100_001));
    check("t5_first_green_b", 32'(light_b), 32'h924 ^ 32'h005);

    // Random req / flash traffic with one extra mid-run reset.
    fa = 0; fb = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) req_a = 2'($urandom);
      if ($urandom_range(0, 5) == 0) req_b = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      if (fa > 0) fa--; else if ($urandom_range(0, 80) == 0) fa = $urandom_range(1, 14);
      if (fb > 0) fb--; else if ($urandom_range(0, 80) == 0) fb = $urandom_range(1, 14);
      flash_a = (fa > 0);
      flash_b = (fb > 0);
      if (c == 700) begin
        #2 reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
      end
      tick;
    end
    flash_a = 1'b0; flash_b = 1'b0;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
